// File: rtl/qpmm_rr_scheduler.sv
// Round-robin front end sharing one fully pipelined QPMM multiplier among N_REQ requesters.
// Optional QPMM_SCHED_STATS_EN adds stat_issued / stat_bubbles saturating counters.
module qpmm_rr_scheduler #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned W     = 280,
   parameter int unsigned LAT   = 58
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       sched_en,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*W-1:0]         req_a,
   input  logic [N_REQ*W-1:0]         req_b,
   output logic [W-1:0]               mm_a,
   output logic [W-1:0]               mm_b,
   input  logic [W-1:0]               mm_z,
   output logic                       rsp_valid,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic [W-1:0]               rsp_z,
   output logic                       idle
`ifdef QPMM_SCHED_STATS_EN
   ,
   output logic [31:0]                stat_issued,
   output logic [31:0]                stat_bubbles
`endif
);

   localparam int unsigned ID_W  = $clog2(N_REQ);
   localparam int unsigned INF_W = $clog2(LAT + 3);
   localparam int unsigned DEPTH = LAT + 1;
   localparam logic [ID_W:0] N_REQ_W = (ID_W+1)'(N_REQ);
   localparam logic [INF_W-1:0] INF_MAX = INF_W'(LAT + 2);

   typedef struct packed {
      logic            v;
      logic [ID_W-1:0] id;
   } tag_t;

   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  winner;
   logic [ID_W-1:0]  nxt_ptr;
   logic [N_REQ-1:0] rot;
   logic             found;
   logic             grant;
   logic [INF_W-1:0] inflight;
   tag_t             tag_q [DEPTH];

   // Rotate requests so rr_ptr sits at bit 0; the lowest set bit of rot wins.
   always_comb begin
      logic [ID_W:0] pos;
      pos    = '0;
      found  = 1'b0;
      winner = '0;
      rot    = N_REQ'({req_valid, req_valid} >> rr_ptr);
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found  = 1'b1;
            pos    = {1'b0, rr_ptr} + (ID_W+1)'(k);
            winner = (pos >= N_REQ_W) ? ID_W'(pos - N_REQ_W) : ID_W'(pos);
         end
      end
   end

   assign grant     = found & sched_en & rstn;
   assign req_ready = grant ? (N_REQ'(1) << winner) : '0;
   assign nxt_ptr   = ({1'b0, winner} + (ID_W+1)'(1) == N_REQ_W) ? '0 : winner + ID_W'(1);
   assign idle      = (inflight == '0) && !grant;

   // Issue stage: operands to the multiplier and the matching tag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rr_ptr <= '0;
         mm_a   <= '0;
         mm_b   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) tag_q[i] <= '0;
      end else begin
         if (grant) begin
            rr_ptr <= nxt_ptr;
            mm_a   <= req_a[32'(winner)*W +: W];
            mm_b   <= req_b[32'(winner)*W +: W];
         end else begin
            mm_a   <= '0;
            mm_b   <= '0;
         end
         tag_q[0] <= '{v: grant, id: grant ? winner : '0};
         for (int unsigned i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   // Response capture; an operation retires as its response is registered.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_z     <= '0;
         inflight  <= '0;
      end else begin
         rsp_valid <= tag_q[LAT].v;
         rsp_id    <= tag_q[LAT].id;
         if (tag_q[LAT].v) rsp_z <= mm_z;
         case ({grant, tag_q[LAT].v})
            2'b10:   inflight <= inflight + INF_W'(1);
            2'b01:   inflight <= inflight - INF_W'(1);
            default: inflight <= inflight;
         endcase
      end
   end

`ifdef QPMM_SCHED_STATS_EN
   // Saturating usage counters.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         stat_issued  <= '0;
         stat_bubbles <= '0;
      end else begin
         if (grant && stat_issued != 32'hFFFF_FFFF) stat_issued <= stat_issued + 32'd1;
         if (sched_en && !grant && !(&req_valid) && stat_bubbles != 32'hFFFF_FFFF)
            stat_bubbles <= stat_bubbles + 32'd1;
      end
   end
`endif

   a_inflight_max: assert property (@(posedge clk) disable iff (!rstn) inflight <= INF_MAX);
   a_inflight_underflow: assert property (@(posedge clk) disable iff (!rstn)
      !(inflight == '0 && tag_q[LAT].v && !grant));

endmodule

// File: tb/tb_qpmm_rr_scheduler.sv
// Scoreboard bench for qpmm_rr_scheduler with a behavioural LAT-deep multiplier stand-in.
module tb_qpmm_rr_scheduler;

   localparam int unsigned N   = 4;
   localparam int unsigned W   = 280;
   localparam int unsigned LAT = 58;
   localparam int unsigned IDW = 2;

   logic             clk = 1'b0;
   logic             rstn;
   logic             sched_en;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_a;
   logic [N*W-1:0]   req_b;
   logic [W-1:0]     mm_a, mm_b, mm_z, rsp_z;
   logic             rsp_valid;
   logic [IDW-1:0]   rsp_id;
   logic             idle;

   logic [W-1:0]     a_op [N];
   logic [W-1:0]     b_op [N];
   logic [W-1:0]     mpipe [LAT];
   logic [W-1:0]     last_z;

   typedef struct {
      logic [IDW-1:0] id;
      logic [W-1:0]   z;
      int             cyc;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   tlast;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = a_op[i];
         req_b[i*W +: W] = b_op[i];
      end
   end

   // Multiplier stand-in: product appears on mm_z LAT edges after mm_a/mm_b.
   always @(posedge clk) begin
      mpipe[0] <= mm_a * mm_b;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mm_z = mpipe[LAT-1];

   qpmm_rr_scheduler #(.N_REQ(N), .W(W), .LAT(LAT)) dut (
      .clk(clk), .rstn(rstn), .sched_en(sched_en),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .mm_a(mm_a), .mm_b(mm_b), .mm_z(mm_z),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z),
      .idle(idle)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [W-1:0] opa(input int id, input int r);
      return (W'(id + 1) << 240) | (W'(r) << 64) | W'(64'h0123_4567_89AB_CDEF);
   endfunction

   function automatic logic [W-1:0] opb(input int id, input int r);
      return (W'(id + 5) << 150) | W'(32'hFACE_0000 + 32'(r));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at the negedge of the cycle in which a grant to id is required.
   task automatic expect_grant(input int id);
      exp_t en;
      chk($sformatf("grant_id%0d", id), W'(req_ready), W'(1) << id);
      chk("idle_during_grant", W'(idle), W'(0));
      en.id  = IDW'(id);
      en.z   = a_op[id] * b_op[id];
      en.cyc = cyc + LAT + 2;
      q.push_back(en);
      last_z = en.z;
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (!(q.size() == 0 && idle === 1'b1) && i < 300) begin
         tick();
         i++;
      end
      n_cmp++;
      if (i >= 300) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d responses outstanding, idle=%0b, required 0 and 1", q.size(), idle);
         q.delete();
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
   endtask

   // Monitor: pops one expectation per response.
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: got id %0d at cyc %0d, required no response", rsp_id, cyc);
         end else begin
            e = q.pop_front();
            chk("rsp_id", W'(rsp_id), W'(e.id));
            chk("rsp_z", rsp_z, e.z);
            chk("rsp_cycle", W'(cyc), W'(e.cyc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0;
      sched_en = 1'b1;
      req_valid = '1;
      for (int i = 0; i < N; i++) begin
         a_op[i] = opa(i, 0);
         b_op[i] = opb(i, 0);
      end
      tick();
      tick();
      @(negedge clk);
      chk("reset_ready", W'(req_ready), W'(0));
      chk("reset_rsp_valid", W'(rsp_valid), W'(0));
      chk("reset_mm_a", mm_a, W'(0));
      chk("reset_rsp_z", rsp_z, W'(0));
      chk("reset_idle", W'(idle), W'(1));
      req_valid = '0;
      tick();
      rstn = 1'b1;

      // Single op on requester 0, A=0 B=1.
      a_op[0] = '0;
      b_op[0] = W'(1);
      req_valid = 4'b0001;
      @(negedge clk);
      expect_grant(0);
      tick();
      req_valid = '0;
      drain();

      // All requesters busy: strict rotation with wrap, new operands after each handshake.
      do_reset();
      for (int i = 0; i < N; i++) begin
         a_op[i] = opa(i, 0);
         b_op[i] = opb(i, 0);
      end
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         expect_grant(k % N);
         tick();
         a_op[k % N] = opa(k % N, k + 1);
         b_op[k % N] = opb(k % N, k + 1);
      end
      req_valid = '0;
      drain();
      tick();
      tick();
      @(negedge clk);
      chk("rsp_z_hold", rsp_z, last_z);
      chk("rsp_valid_low", W'(rsp_valid), W'(0));
      tick();

      // Reset while ten operations are in flight drops all of them.
      do_reset();
      req_valid = 4'b1111;
      repeat (10) tick();
      req_valid = '0;
      repeat (5) tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      @(negedge clk);
      chk("post_reset_mm_a", mm_a, W'(0));
      for (int i = 0; i < 70; i++) begin
         chk("post_reset_rsp_valid", W'(rsp_valid), W'(0));
         chk("post_reset_idle", W'(idle), W'(1));
         tick();
         @(negedge clk);
      end
      tick();
      req_valid = 4'b1111;
      @(negedge clk);
      expect_grant(0);
      tick();
      req_valid = '0;
      drain();

      // sched_en stall with rr_ptr=2, pending on 1 and 3; idle timing after last grant.
      do_reset();
      req_valid = 4'b0010;
      @(negedge clk);
      expect_grant(1);
      tick();
      req_valid = 4'b1010;
      sched_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_ready", W'(req_ready), W'(0));
         tick();
      end
      sched_en = 1'b1;
      @(negedge clk);
      expect_grant(3);
      tick();
      req_valid = 4'b0010;
      @(negedge clk);
      expect_grant(1);
      tlast = cyc;
      tick();
      req_valid = '0;
      while (cyc < tlast + LAT + 1) tick();
      @(negedge clk);
      chk("idle_before_last_rsp", W'(idle), W'(0));
      tick();
      @(negedge clk);
      chk("idle_at_last_rsp", W'(idle), W'(1));
      tick();
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
